// File: rtl/seg7_scan_drv_if.sv
// Display link between the wash controller (master) and the 7-segment scan driver (slave).
// Carries the digit load strobe, digit codes and blink mask in, and the pin-level scan outputs back.
interface seg7_scan_drv_if;
    logic       load;
    logic [3:0] dig3;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [3:0] blink_mask;
    logic [3:0] ena;
    logic [7:0] led;
    logic       frame;

    modport master (
        output load, dig3, dig2, dig1, dig0, blink_mask,
        input  ena, led, frame
    );

    modport slave (
        input  load, dig3, dig2, dig1, dig0, blink_mask,
        output ena, led, frame
    );
endinterface

// File: rtl/seg7_scan_drv.sv
// Double-buffered 4-digit 7-segment scan driver; the active buffer is only refreshed at frame start.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg7_scan_drv #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    seg7_scan_drv_if.slave disp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [15:0] BLANK_DIGITS = 16'hBBBB;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            4'd0:    seg = 8'hFC;
            4'd1:    seg = 8'h60;
            4'd2:    seg = 8'hDA;
            4'd3:    seg = 8'hF2;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'hB6;
            4'd6:    seg = 8'hBE;
            4'd7:    seg = 8'hE0;
            4'd8:    seg = 8'hFE;
            4'd9:    seg = 8'hF6;
            4'd10:   seg = 8'h02;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      active_q, active_d;
    logic [3:0]       ena_q, ena_d;
    logic [7:0]       led_q, led_d;
    logic             frame_q, frame_d;

    logic             cnt_last;
    logic             frame_start;
    logic             blank_w;
    logic [7:0]       seg_w [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign seg_w[gi] = seg_decode(active_q[gi*4 +: 4]);
        end
    endgenerate

    assign cnt_last    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_start = cnt_last && (idx_q == 2'd0);

`ifdef SEG_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blank_w = phase_q & disp.blink_mask[idx_q];
`else
    logic unused_blink;
    assign unused_blink = (^disp.blink_mask) ^ (BLINK_DIV == 32'd0);
    assign blank_w      = 1'b0;
`endif

    logic unused_clk_hz;
    assign unused_clk_hz = (CLK_HZ == 32'd0);

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        if (cnt_last) begin
            cnt_d = '0;
            idx_d = idx_q - 2'd1;
        end
        // Active copy samples the pre-load shadow, so a load on the frame edge shows one frame later.
        if (frame_start) begin
            active_d = shadow_q;
        end
        if (disp.load) begin
            shadow_d = {disp.dig3, disp.dig2, disp.dig1, disp.dig0};
        end
        frame_d = frame_start;
        ena_d   = 4'b0001 << idx_q;
        led_d   = blank_w ? 8'h00 : seg_w[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd3;
            shadow_q <= BLANK_DIGITS;
            active_q <= BLANK_DIGITS;
            ena_q    <= 4'b0000;
            led_q    <= 8'h00;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ena_q    <= ena_d;
            led_q    <= led_d;
            frame_q  <= frame_d;
        end
    end

    assign disp.ena   = ena_q;
    assign disp.led   = led_q;
    assign disp.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with REFRESH_DIV=4 and BLINK_DIV=16; frame-aligned checks of ena/led/frame.
// Blink expectations follow SEG_BLINK_EN, matching the RTL build.
module tb_seg7_scan_drv;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_drv_if disp_if ();

    seg7_scan_drv #(
        .CLK_HZ      (100_000_000),
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .disp (disp_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Samples one full frame (16 cycles) starting the cycle after a frame edge or reset release.
    // Optionally drives a one-cycle load right after sample ld_at; ld_at=14 lands on the frame edge.
    task automatic check_frame(input string tag,
                               input logic [7:0] e3, input logic [7:0] e2,
                               input logic [7:0] e1, input logic [7:0] e0,
                               input int ld_at, input logic [15:0] ld_val,
                               input logic [3:0] mask_val);
        logic [7:0] exp_led [4];
        int         slot;
        exp_led[0] = e3;
        exp_led[1] = e2;
        exp_led[2] = e1;
        exp_led[3] = e0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            slot = c / 4;
            chk($sformatf("%s.ena%0d", tag, c), {28'd0, disp_if.ena}, {28'd0, 4'b1000 >> slot});
            chk($sformatf("%s.led%0d", tag, c), {24'd0, disp_if.led}, {24'd0, exp_led[slot]});
            chk($sformatf("%s.frm%0d", tag, c), {31'd0, disp_if.frame}, {31'd0, (c == 15)});
            if (c == ld_at) begin
                disp_if.load = 1'b1;
                {disp_if.dig3, disp_if.dig2, disp_if.dig1, disp_if.dig0} = ld_val;
                disp_if.blink_mask = mask_val;
            end else begin
                disp_if.load = 1'b0;
            end
        end
        $display("frame %s: led %h %h %h %h checked, %0d mismatches so far", tag, e3, e2, e1, e0, n_err);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".ena"},   {28'd0, disp_if.ena},   32'd0);
        chk({tag, ".led"},   {24'd0, disp_if.led},   32'd0);
        chk({tag, ".frame"}, {31'd0, disp_if.frame}, 32'd0);
    endtask

    logic [7:0] blink_led;

    initial begin
        disp_if.load       = 1'b0;
        disp_if.dig3       = 4'd0;
        disp_if.dig2       = 4'd0;
        disp_if.dig1       = 4'd0;
        disp_if.dig0       = 4'd0;
        disp_if.blink_mask = 4'b0000;
`ifdef SEG_BLINK_EN
        blink_led = 8'h00;
`else
        blink_led = 8'hF2;
`endif

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset($sformatf("rst%0d", i));
            $display("reset cycle %0d: ena %b led %h frame %b", i, disp_if.ena, disp_if.led, disp_if.frame);
        end
        rst = 1'b0;

        // Load lands on the cycle before the frame edge, so it shows in the very next frame.
        check_frame("f1_blank", 8'h00, 8'h00, 8'h00, 8'h00, 13, {4'd1, 4'd11, 4'd6, 4'd0}, 4'b0000);
        // Mid-frame load while ena=0100 must not tear the current frame.
        check_frame("f2_60",    8'h60, 8'h00, 8'hBE, 8'hFC, 5,  {4'd5, 4'd11, 4'd4, 4'd5}, 4'b0000);
        // Load exactly on the frame edge: old digits for one more frame.
        check_frame("f3_tear",  8'hB6, 8'h00, 8'h66, 8'hB6, 14, {4'd10, 4'd12, 4'd13, 4'd15}, 4'b0000);
        check_frame("f4_coll",  8'hB6, 8'h00, 8'h66, 8'hB6, -1, 16'h0000, 4'b0000);
        check_frame("f5_codes", 8'h02, 8'h00, 8'h00, 8'h00, 13, {4'd3, 4'd11, 4'd2, 4'd0}, 4'b1000);
        check_frame("f6_blnk1", blink_led, 8'h00, 8'hDA, 8'hFC, -1, 16'h0000, 4'b1000);
        check_frame("f7_blnk0", 8'hF2, 8'h00, 8'hDA, 8'hFC, -1, 16'h0000, 4'b1000);

        // Reset in the middle of a frame returns to blank with idx back at the leftmost digit.
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset($sformatf("mrst%0d", i));
            $display("mid-frame reset cycle %0d: ena %b led %h", i, disp_if.ena, disp_if.led);
        end
        rst = 1'b0;
        check_frame("f8_rblank", 8'h00, 8'h00, 8'h00, 8'h00, -1, 16'h0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
